// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the two-master bus arbiter:
//   state_t      - arbiter FSM state encoding (IDLE / ISSUE / RESP)
//   master_idx_t - index of a bus master (0 = CPU data port, 1 = DMA/loader)
//   hit_t        - one-hot address decode result {ram, rom, led, none}
//   DEF_*        - default address map
// ---------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef logic master_idx_t;

  typedef struct packed {
    logic ram;
    logic rom;
    logic led;
    logic none;
  } hit_t;

  localparam logic [31:0] DEF_RAM_BASE = 32'h1000_0000;
  localparam logic [31:0] DEF_RAM_SIZE = 32'd256;
  localparam logic [31:0] DEF_ROM_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_ROM_SIZE = 32'd256;
  localparam logic [31:0] DEF_LED_ADDR = 32'h2000_0000;

endpackage

// File: rtl/bus_arbiter_addr_decoder.sv
// ---------------------------------------------------------------------------
// addr_decoder
// Combinational address decoder for the arbiter's slave map.
// Ports:
//   addr_i : 32-bit byte address
//   hit_o  : one-hot {ram, rom, led, none}; priority RAM > ROM > LED
// ---------------------------------------------------------------------------
module addr_decoder
  import bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
  parameter logic [31:0] RAM_SIZE = DEF_RAM_SIZE,
  parameter logic [31:0] ROM_BASE = DEF_ROM_BASE,
  parameter logic [31:0] ROM_SIZE = DEF_ROM_SIZE,
  parameter logic [31:0] LED_ADDR = DEF_LED_ADDR
) (
  input  logic [31:0] addr_i,
  output hit_t        hit_o
);

  logic [32:0] ram_off;
  logic [32:0] rom_off;
  logic        ram_hit;
  logic        rom_hit;
  logic        led_hit;

  // Window test in 33 bits: an address below the base underflows into
  // bit 32, so the offset can never compare below the window size, and
  // base+size near the top of the address space cannot wrap.
  always_comb begin
    ram_off = {1'b0, addr_i} - {1'b0, RAM_BASE};
    rom_off = {1'b0, addr_i} - {1'b0, ROM_BASE};
    ram_hit = ram_off < {1'b0, RAM_SIZE};
    rom_hit = rom_off < {1'b0, ROM_SIZE};
    led_hit = addr_i == LED_ADDR;

    hit_o      = '0;
    hit_o.ram  = ram_hit;
    hit_o.rom  = rom_hit && !ram_hit;
    hit_o.led  = led_hit && !ram_hit && !rom_hit;
    hit_o.none = !(ram_hit || rom_hit || led_hit);
  end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Two-master, single-outstanding bus arbiter onto a RAM / ROM / LED slave map.
// Each transfer takes IDLE (arbitrate + latch) -> ISSUE (gnt, slave enables)
// -> RESP (rvalid, rdata, err), i.e. at most one transfer per 3 cycles.
//
// Build option:
//   BUS_ARBITER_RR_EN defined   : round-robin between simultaneous requests
//   BUS_ARBITER_RR_EN undefined : fixed priority, m0 always wins
//
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   mN_req/addr/wdata/wen            : master N request (wen == 0 is a read)
//   mN_gnt                           : request accepted (pulse, ISSUE)
//   mN_rvalid/rdata/err              : response (pulse, RESP)
//   s_addr, s_wdata                  : shared slave address / write data
//   s_wen_ram, s_led_wr              : RAM byte enables, LED write strobe
//   s_rdata_ram/rom/led              : slave read data
// ---------------------------------------------------------------------------
module bus_arbiter
  import bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
  parameter logic [31:0] RAM_SIZE = DEF_RAM_SIZE,
  parameter logic [31:0] ROM_BASE = DEF_ROM_BASE,
  parameter logic [31:0] ROM_SIZE = DEF_ROM_SIZE,
  parameter logic [31:0] LED_ADDR = DEF_LED_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wen,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wen,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wen_ram,
  output logic        s_led_wr,
  input  logic [31:0] s_rdata_ram,
  input  logic [31:0] s_rdata_rom,
  input  logic [31:0] s_rdata_led
);

  state_t      state_q;
  master_idx_t idx_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wen_q;
  hit_t        hit_q;
  logic [1:0]  gnt_q;
  logic [1:0]  rvalid_q;
  logic [3:0]  wen_ram_q;
  logic        led_wr_q;
`ifdef BUS_ARBITER_RR_EN
  master_idx_t last_q;
`endif

  master_idx_t win_d;
  logic [31:0] win_addr_d;
  logic [31:0] win_wdata_d;
  logic [3:0]  win_wen_d;
  hit_t        win_hit_d;
  logic [31:0] rdata_sel;

  // Winner selection; only consumed in IDLE when some request is high.
  always_comb begin
`ifdef BUS_ARBITER_RR_EN
    if (m0_req && m1_req) win_d = ~last_q;
    else                  win_d = master_idx_t'(m1_req);
`else
    win_d = master_idx_t'(!m0_req);
`endif
    win_addr_d  = win_d ? m1_addr  : m0_addr;
    win_wdata_d = win_d ? m1_wdata : m0_wdata;
    win_wen_d   = win_d ? m1_wen   : m0_wen;
  end

  // Decoding the winner's address before latching lets the slave enables
  // be registered outputs that are already valid in ISSUE.
  addr_decoder #(
    .RAM_BASE (RAM_BASE),
    .RAM_SIZE (RAM_SIZE),
    .ROM_BASE (ROM_BASE),
    .ROM_SIZE (ROM_SIZE),
    .LED_ADDR (LED_ADDR)
  ) u_dec (
    .addr_i (win_addr_d),
    .hit_o  (win_hit_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= '0;
      hit_q     <= '0;
      gnt_q     <= '0;
      rvalid_q  <= '0;
      wen_ram_q <= '0;
      led_wr_q  <= 1'b0;
`ifdef BUS_ARBITER_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      gnt_q     <= '0;
      rvalid_q  <= '0;
      wen_ram_q <= '0;
      led_wr_q  <= 1'b0;
      case (state_q)
        // IDLE -> ISSUE: arbitrate, latch payload, set up this cycle's strobes
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            state_q   <= ST_ISSUE;
            idx_q     <= win_d;
            addr_q    <= win_addr_d;
            wdata_q   <= win_wdata_d;
            wen_q     <= win_wen_d;
            hit_q     <= win_hit_d;
            gnt_q     <= win_d ? 2'b10 : 2'b01;
            wen_ram_q <= win_hit_d.ram ? win_wen_d : 4'b0000;
            led_wr_q  <= win_hit_d.led && (win_wen_d == 4'b1111);
`ifdef BUS_ARBITER_RR_EN
            last_q    <= win_d;
`endif
          end
        end
        // ISSUE -> RESP: slave samples address now, data returns next cycle
        ST_ISSUE: begin
          state_q  <= ST_RESP;
          rvalid_q <= idx_q ? 2'b10 : 2'b01;
        end
        // RESP -> IDLE
        ST_RESP:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Slave data arrives one cycle after ISSUE, so read data is steered
  // combinationally during RESP rather than registered.
  always_comb begin
    rdata_sel = '0;
    if (wen_q == 4'b0000) begin
      if (hit_q.ram)      rdata_sel = s_rdata_ram;
      else if (hit_q.rom) rdata_sel = s_rdata_rom;
      else if (hit_q.led) rdata_sel = s_rdata_led;
    end
  end

  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rvalid_q[0] ? rdata_sel : '0;
  assign m1_rdata  = rvalid_q[1] ? rdata_sel : '0;
  assign m0_err    = rvalid_q[0] & hit_q.none;
  assign m1_err    = rvalid_q[1] & hit_q.none;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign s_wen_ram = wen_ram_q;
  assign s_led_wr  = led_wr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Directed scenarios followed by randomized traffic from both masters,
// compared cycle by cycle against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam logic [31:0] RAMB = 32'h1000_0000;
  localparam logic [31:0] LEDA = 32'h2000_0000;
  localparam logic [31:0] RAM_DATA = 32'hDEAD_BEEF;
  localparam logic [31:0] ROM_DATA = 32'h0B0B_0B0B;
  localparam logic [31:0] LED_DATA = 32'h0000_00A5;
`ifdef BUS_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wen, m1_wen;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wen_ram;
  logic        s_led_wr;
  logic [31:0] s_rdata_ram, s_rdata_rom, s_rdata_led;

  always #5 clk = ~clk;

  bus_arbiter #(
    .RAM_BASE (32'h1000_0000), .RAM_SIZE (32'd256),
    .ROM_BASE (32'h0000_0000), .ROM_SIZE (32'd256),
    .LED_ADDR (32'h2000_0000)
  ) dut (
    .clk (clk), .rst (rst),
    .m0_req (m0_req), .m0_addr (m0_addr), .m0_wdata (m0_wdata), .m0_wen (m0_wen),
    .m0_gnt (m0_gnt), .m0_rvalid (m0_rvalid), .m0_rdata (m0_rdata), .m0_err (m0_err),
    .m1_req (m1_req), .m1_addr (m1_addr), .m1_wdata (m1_wdata), .m1_wen (m1_wen),
    .m1_gnt (m1_gnt), .m1_rvalid (m1_rvalid), .m1_rdata (m1_rdata), .m1_err (m1_err),
    .s_addr (s_addr), .s_wdata (s_wdata), .s_wen_ram (s_wen_ram), .s_led_wr (s_led_wr),
    .s_rdata_ram (s_rdata_ram), .s_rdata_rom (s_rdata_rom), .s_rdata_led (s_rdata_led)
  );

  int total = 0;
  int bad   = 0;

  // master-side request bookkeeping
  bit          pend_v[2];
  logic [31:0] pend_a[2], pend_d[2];
  logic [3:0]  pend_w[2];
  bit random_mode = 1'b0, hold_req = 1'b0, rst_nxt = 1'b1, rst_on_gnt1 = 1'b0;
  bit [1:0] gnt_obs;

  // observations
  int          glog[$];
  logic [31:0] rd_last[2];
  logic        err_last[2];
  int          rv_cnt[2];
  int          en_cnt = 0, led_cnt = 0;
  logic [31:0] led_wd;

  // reference model: the transfer in flight and its age in cycles
  int          age = 0;
  bit          m_idx, m_last = 1'b1, after_rst = 1'b1;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wen;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // 0 = RAM, 1 = ROM, 2 = LED, 3 = unmapped
  function automatic int region(input logic [31:0] a);
    longint unsigned x, rb;
    x  = 64'(a);
    rb = 64'(RAMB);
    if (x >= rb && x < rb + 64'd256) return 0;
    if (x < 64'd256) return 1;
    if (a == LEDA) return 2;
    return 3;
  endfunction

  task automatic compare();
    int rgn;
    logic [31:0] rd;
    logic [1:0]  e_gnt, e_rv;
    logic        e_err;
    rgn   = region(m_addr);
    e_gnt = (age == 1) ? (m_idx ? 2'b10 : 2'b01) : 2'b00;
    e_rv  = (age == 2) ? (m_idx ? 2'b10 : 2'b01) : 2'b00;
    e_err = (age == 2) && (rgn == 3);
    rd = '0;
    if (age == 2 && m_wen == 4'h0) begin
      case (rgn)
        0:       rd = s_rdata_ram;
        1:       rd = s_rdata_rom;
        2:       rd = s_rdata_led;
        default: rd = '0;
      endcase
    end
    check_val("gnt",    {m1_gnt, m0_gnt}, e_gnt);
    check_val("rvalid", {m1_rvalid, m0_rvalid}, e_rv);
    check_val("err",    {m1_err, m0_err}, {e_rv[1] & e_err, e_rv[0] & e_err});
    check_val("m0_rdata", m0_rdata, e_rv[0] ? rd : 32'h0);
    check_val("m1_rdata", m1_rdata, e_rv[1] ? rd : 32'h0);
    check_val("s_wen_ram", s_wen_ram, (age == 1 && rgn == 0) ? m_wen : 4'h0);
    check_val("s_led_wr", s_led_wr, age == 1 && rgn == 2 && m_wen == 4'hF);
    if (after_rst) begin
      check_val("rst_s_addr", s_addr, 32'h0);
      check_val("rst_s_wdata", s_wdata, 32'h0);
    end else if (age == 1) begin
      check_val("s_addr", s_addr, m_addr);
      check_val("s_wdata", s_wdata, m_wdata);
    end
    gnt_obs = {m1_gnt, m0_gnt};
    if (m0_gnt) glog.push_back(0);
    if (m1_gnt) glog.push_back(1);
    if (m0_rvalid) begin rd_last[0] = m0_rdata; err_last[0] = m0_err; rv_cnt[0]++; end
    if (m1_rvalid) begin rd_last[1] = m1_rdata; err_last[1] = m1_err; rv_cnt[1]++; end
    if (s_wen_ram != 4'h0 || s_led_wr) en_cnt++;
    if (s_led_wr) begin led_cnt++; led_wd = s_wdata; end
  endtask

  task automatic new_req(input int n);
    logic [31:0] a;
    logic [3:0]  w;
    case ($urandom_range(0, 9))
      0, 1:    a = RAMB + $urandom_range(0, 255);
      2:       a = 32'h1000_00FF;
      3:       a = 32'h1000_0100;
      4:       a = 32'h0FFF_FFFF;
      5:       a = 32'($urandom_range(0, 255));
      6:       a = 32'h0000_0100;
      7:       a = LEDA;
      8:       a = LEDA + 32'd4;
      default: a = $urandom();
    endcase
    case ($urandom_range(0, 5))
      0, 1:    w = 4'h0;
      2:       w = 4'hF;
      3:       w = 4'h3;
      4:       w = 4'h1;
      default: w = 4'($urandom());
    endcase
    pend_a[n] = a; pend_d[n] = $urandom(); pend_w[n] = w; pend_v[n] = 1'b1;
  endtask

  task automatic drive();
    for (int n = 0; n < 2; n++) begin
      if (gnt_obs[n] && !hold_req) pend_v[n] = 1'b0;
      if (random_mode) begin
        if (!pend_v[n] && $urandom_range(0, 99) < 35) new_req(n);
        else if (pend_v[n] && !gnt_obs[n] && $urandom_range(0, 99) < 3) pend_v[n] = 1'b0;
      end
    end
    if (rst_on_gnt1 && gnt_obs[1]) rst_nxt = 1'b1;
    rst = rst_nxt;
    m0_req = pend_v[0]; m0_addr = pend_a[0]; m0_wdata = pend_d[0]; m0_wen = pend_w[0];
    m1_req = pend_v[1]; m1_addr = pend_a[1]; m1_wdata = pend_d[1]; m1_wen = pend_w[1];
    if (random_mode) begin
      s_rdata_ram = $urandom(); s_rdata_rom = $urandom(); s_rdata_led = $urandom();
    end else begin
      s_rdata_ram = RAM_DATA; s_rdata_rom = ROM_DATA; s_rdata_led = LED_DATA;
    end
  endtask

  // What happens at the coming rising edge, in transaction terms.
  task automatic model_step();
    bit w;
    if (rst) begin
      age = 0; m_last = 1'b1; after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (age == 1)      age = 2;
      else if (age == 2) age = 0;
      else if (m0_req || m1_req) begin
        if (m0_req && m1_req) w = RR ? !m_last : 1'b0;
        else                  w = m1_req;
        m_idx   = w;
        m_addr  = w ? m1_addr  : m0_addr;
        m_wdata = w ? m1_wdata : m0_wdata;
        m_wen   = w ? m1_wen   : m0_wen;
        m_last  = w;
        age     = 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    drive();
    model_step();
  endtask

  task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    pend_a[n] = a; pend_d[n] = d; pend_w[n] = w; pend_v[n] = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((pend_v[0] || pend_v[1] || age != 0) && n < 60);
    check_val({tag, "_timeout"}, 32'(n >= 60), 32'h0);
  endtask

  task automatic xfer(input int n, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    set_req(n, a, d, w);
    wait_idle("xfer");
  endtask

  initial begin
    int n;
    rst = 1'b1; m0_req = 0; m1_req = 0;
    m0_addr = 0; m0_wdata = 0; m0_wen = 0; m1_addr = 0; m1_wdata = 0; m1_wen = 0;
    s_rdata_ram = RAM_DATA; s_rdata_rom = ROM_DATA; s_rdata_led = LED_DATA;
    pend_v[0] = 0; pend_v[1] = 0; gnt_obs = 0; rv_cnt[0] = 0; rv_cnt[1] = 0;
    pend_a[0] = 0; pend_a[1] = 0; pend_d[0] = 0; pend_d[1] = 0; pend_w[0] = 0; pend_w[1] = 0;
    model_step();
    tick(); tick();
    check_val("reset_outputs", {m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, m1_err, m0_err, s_led_wr},
              7'b0);
    rst_nxt = 1'b0;
    tick();

    // contention right after reset: both masters keep requesting
    glog.delete();
    hold_req = 1'b1;
    set_req(0, RAMB + 32'h10, 0, 4'h0);
    set_req(1, RAMB + 32'h20, 0, 4'h0);
    n = 0;
    while (glog.size() < 4 && n < 40) begin tick(); n++; end
    hold_req = 1'b0;
    check_val("cont_timeout", 32'(n >= 40), 32'h0);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("cont_order%0d", i), (glog.size() > i) ? glog[i] : -1,
                RR ? (i % 2) : 0);
    wait_idle("cont");

    // single read with latency
    set_req(0, 32'h1000_0004, 0, 4'h0);
    tick();
    tick(); check_val("rd_gnt_t1", m0_gnt, 1'b1);
    tick(); check_val("rd_rvalid_t2", m0_rvalid, 1'b1);
    check_val("rd_rdata", m0_rdata, RAM_DATA);
    check_val("rd_err", m0_err, 1'b0);
    wait_idle("rd");

    // LED full and partial writes
    led_cnt = 0;
    xfer(1, LEDA, 32'h5, 4'hF);
    check_val("led_strobe_cnt", led_cnt, 1);
    check_val("led_wdata", led_wd, 32'h5);
    led_cnt = 0;
    xfer(1, LEDA, 32'h5, 4'h3);
    check_val("led_partial_cnt", led_cnt, 0);
    check_val("led_partial_err", err_last[1], 1'b0);

    // unmapped and dropped accesses
    en_cnt = 0;
    xfer(0, 32'h3000_0000, 0, 4'h0);
    check_val("unmap_rd_rdata", rd_last[0], 32'h0);
    check_val("unmap_rd_err", err_last[0], 1'b1);
    xfer(0, 32'h3000_0000, 32'h77, 4'hF);
    check_val("unmap_wr_err", err_last[0], 1'b1);
    xfer(1, 32'h0000_0010, 32'h99, 4'hF);
    check_val("rom_wr_err", err_last[1], 1'b0);
    check_val("no_enables", en_cnt, 0);

    // window boundaries
    xfer(0, 32'h1000_00FF, 0, 4'h0);
    check_val("ram_top_rdata", rd_last[0], RAM_DATA);
    check_val("ram_top_err", err_last[0], 1'b0);
    xfer(0, 32'h1000_0100, 0, 4'h0);
    check_val("ram_end_err", err_last[0], 1'b1);
    xfer(0, 32'h0000_00FC, 0, 4'h0);
    check_val("rom_rdata", rd_last[0], ROM_DATA);

    // reset while an m1 write is in ISSUE
    rv_cnt[1] = 0;
    rst_on_gnt1 = 1'b1;
    set_req(1, RAMB + 32'h40, 32'h1234, 4'hF);
    n = 0;
    do begin tick(); n++; end while (!rst && n < 20);
    rst_on_gnt1 = 1'b0;
    rst_nxt = 1'b0;
    check_val("rstmid_timeout", 32'(n >= 20), 32'h0);
    tick(); tick(); tick();
    check_val("rstmid_no_rvalid", rv_cnt[1], 0);
    glog.delete();
    set_req(0, RAMB, 0, 4'h0);
    set_req(1, RAMB + 32'h4, 0, 4'h0);
    n = 0;
    while (glog.size() < 1 && n < 20) begin tick(); n++; end
    check_val("rstmid_first_gnt", (glog.size() > 0) ? glog[0] : -1, 0);
    wait_idle("rstmid");

    // randomized traffic
    random_mode = 1'b1;
    repeat (1500) tick();
    random_mode = 1'b0;
    wait_idle("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=done");
    $fatal(1, "watchdog");
  end

endmodule
